// File: rtl/nibble_link_tx.sv
// -----------------------------------------------------------------------------
// nibble_link_tx
//
// Initiator side of the C/x0/x1/x2 nibble link. A byte transaction (command +
// data) is accepted on a valid/ready port and sent to the responder as two
// 4-bit beats: low nibble first, then high nibble. Each beat raises x0 with
// the nibble on x1 and waits for the responder's x2 acknowledge. A beat that
// waits TIMEOUT cycles without an acknowledge aborts the transaction.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_valid     upstream transaction valid
//   in_ready     high only in IDLE (decoded from state)
//   in_cmd       command byte, captured on accept
//   in_data      data byte, captured on accept
//   C            captured command, stable for the whole transaction
//   x0           beat strobe to responder (registered)
//   x1           beat nibble, valid while x0 = 1 (registered)
//   x2           responder acknowledge, sampled at posedge
//   busy         high in any state other than IDLE (decoded from state)
//   timeout_err  one-cycle pulse when a beat times out (registered)
//   sent_count   fully acknowledged transactions, wraps (registered)
//
// Parameters
//   TIMEOUT      max cycles a beat waits for x2 before abort (>= 1)
//   COUNT_WIDTH  width of sent_count
// -----------------------------------------------------------------------------
module nibble_link_tx #(
  parameter int TIMEOUT     = 15,
  parameter int COUNT_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [7:0]             in_cmd,
  input  logic [7:0]             in_data,
  output logic [7:0]             C,
  output logic                   x0,
  output logic [3:0]             x1,
  input  logic                   x2,
  output logic                   busy,
  output logic                   timeout_err,
  output logic [COUNT_WIDTH-1:0] sent_count
);

  // The wait counter only has to hold 0 .. TIMEOUT-1: the edge at which it
  // would reach TIMEOUT is the abort edge, so it never stores TIMEOUT itself.
  localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND_LO = 2'd1,
    GAP     = 2'd2,
    SEND_HI = 2'd3
  } state_t;

  state_t                 state;
  state_t                 next_state;

  logic [7:0]             data_reg;
  logic [WAIT_W-1:0]      wait_cnt;

  // Next values for every registered output and datapath register.
  logic [7:0]             c_nxt;
  logic [7:0]             data_nxt;
  logic                   x0_nxt;
  logic [3:0]             x1_nxt;
  logic                   terr_nxt;
  logic [COUNT_WIDTH-1:0] sent_nxt;
  logic [WAIT_W-1:0]      wait_nxt;

  // Acknowledge wins over timeout when both happen on the same edge.
  logic                   beat_ack;
  logic                   beat_expired;

  assign beat_ack     = x2;
  assign beat_expired = (!x2) && (wait_cnt == WAIT_LAST);

  // State register plus all registered outputs and datapath flops.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      C           <= 8'h00;
      data_reg    <= 8'h00;
      x0          <= 1'b0;
      x1          <= 4'h0;
      timeout_err <= 1'b0;
      sent_count  <= '0;
      wait_cnt    <= '0;
    end else begin
      state       <= next_state;
      C           <= c_nxt;
      data_reg    <= data_nxt;
      x0          <= x0_nxt;
      x1          <= x1_nxt;
      timeout_err <= terr_nxt;
      sent_count  <= sent_nxt;
      wait_cnt    <= wait_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          next_state = SEND_LO;
        end else begin
          next_state = IDLE;
        end
      end
      SEND_LO: begin
        if (beat_ack) begin
          next_state = GAP;
        end else if (beat_expired) begin
          next_state = IDLE;
        end else begin
          next_state = SEND_LO;
        end
      end
      GAP: begin
        // x2 is deliberately ignored here; a level-high x2 carried through
        // GAP acknowledges the first SEND_HI cycle instead.
        next_state = SEND_HI;
      end
      SEND_HI: begin
        if (beat_ack) begin
          next_state = IDLE;
        end else if (beat_expired) begin
          next_state = IDLE;
        end else begin
          next_state = SEND_HI;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Output / datapath next values. Every registered output holds by default,
  // which gives "C holds in IDLE" and "x1 holds while x0 = 0" for free.
  always_comb begin
    c_nxt    = C;
    data_nxt = data_reg;
    x0_nxt   = x0;
    x1_nxt   = x1;
    terr_nxt = 1'b0;
    sent_nxt = sent_count;
    wait_nxt = wait_cnt;
    case (state)
      IDLE: begin
        if (in_valid) begin
          c_nxt    = in_cmd;
          data_nxt = in_data;
          x0_nxt   = 1'b1;
          x1_nxt   = in_data[3:0];
          wait_nxt = '0;
        end else begin
          x0_nxt   = 1'b0;
        end
      end
      SEND_LO: begin
        if (beat_ack) begin
          x0_nxt   = 1'b0;
        end else if (beat_expired) begin
          x0_nxt   = 1'b0;
          terr_nxt = 1'b1;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      GAP: begin
        x0_nxt   = 1'b1;
        x1_nxt   = data_reg[7:4];
        wait_nxt = '0;
      end
      SEND_HI: begin
        if (beat_ack) begin
          x0_nxt   = 1'b0;
          sent_nxt = sent_count + COUNT_WIDTH'(1);
        end else if (beat_expired) begin
          x0_nxt   = 1'b0;
          terr_nxt = 1'b1;
        end else begin
          wait_nxt = wait_cnt + WAIT_W'(1);
        end
      end
      default: begin
        x0_nxt   = 1'b0;
      end
    endcase
  end

  // Handshake flags are pure state decodes.
  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_nibble_link_tx.sv
module tb_nibble_link_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_cmd;
  logic [7:0] in_data;
  logic       x2;

  logic       in_ready, busy, timeout_err, x0;
  logic [7:0] c_out;
  logic [3:0] x1;
  logic [7:0] sent_count;

  logic       w_in_ready, w_busy, w_timeout_err, w_x0;
  logic [7:0] w_c;
  logic [3:0] w_x1;
  logic [1:0] w_sent_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  nibble_link_tx #(.TIMEOUT(15), .COUNT_WIDTH(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_cmd(in_cmd), .in_data(in_data), .C(c_out), .x0(x0), .x1(x1),
    .x2(x2), .busy(busy), .timeout_err(timeout_err), .sent_count(sent_count)
  );

  // Narrow-counter instance sharing the same stimulus, for the wrap check.
  nibble_link_tx #(.TIMEOUT(15), .COUNT_WIDTH(2)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(w_in_ready),
    .in_cmd(in_cmd), .in_data(in_data), .C(w_c), .x0(w_x0), .x1(w_x1),
    .x2(x2), .busy(w_busy), .timeout_err(w_timeout_err), .sent_count(w_sent_count)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one clock; inputs and checks happen 1ns after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  // Accept one transaction at the next edge; afterwards we are in cycle N+1.
  task automatic accept(input logic [7:0] cmd, input logic [7:0] data);
    in_valid = 1'b1;
    in_cmd   = cmd;
    in_data  = data;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_cmd = 8'h00; in_data = 8'h00; x2 = 1'b0;
    #1;
    do_reset();

    // Reset state
    chk("rst_x0",    {31'd0, x0}, 32'd0);
    chk("rst_C",     {24'd0, c_out}, 32'h00);
    chk("rst_x1",    {28'd0, x1}, 32'h0);
    chk("rst_busy",  {31'd0, busy}, 32'd0);
    chk("rst_terr",  {31'd0, timeout_err}, 32'd0);
    chk("rst_sent",  {24'd0, sent_count}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);

    // 1. Single transaction, x2 one cycle after each x0 rise
    accept(8'hA5, 8'h3C);
    in_valid = 1'b1;                       // must be ignored while busy
    chk("t1_lo_x0",    {31'd0, x0}, 32'd1);
    chk("t1_lo_x1",    {28'd0, x1}, 32'hC);
    chk("t1_lo_C",     {24'd0, c_out}, 32'hA5);
    chk("t1_lo_ready", {31'd0, in_ready}, 32'd0);
    chk("t1_lo_busy",  {31'd0, busy}, 32'd1);
    step();
    x2 = 1'b1;
    chk("t1_lo_hold_x1", {28'd0, x1}, 32'hC);
    step();
    x2 = 1'b0;
    chk("t1_gap_x0", {31'd0, x0}, 32'd0);
    chk("t1_gap_x1", {28'd0, x1}, 32'hC);
    chk("t1_gap_C",  {24'd0, c_out}, 32'hA5);
    step();
    chk("t1_hi_x0", {31'd0, x0}, 32'd1);
    chk("t1_hi_x1", {28'd0, x1}, 32'h3);
    step();
    in_valid = 1'b0;
    x2 = 1'b1;
    chk("t1_hi_C", {24'd0, c_out}, 32'hA5);
    step();
    x2 = 1'b0;
    chk("t1_end_x0",    {31'd0, x0}, 32'd0);
    chk("t1_end_sent",  {24'd0, sent_count}, 32'd1);
    chk("t1_end_ready", {31'd0, in_ready}, 32'd1);
    chk("t1_end_C",     {24'd0, c_out}, 32'hA5);

    // 2. Immediate ack, 4-cycle latency and back-to-back
    do_reset();
    x2 = 1'b1;
    accept(8'h11, 8'h22);
    step();
    step();
    chk("t2_hi_x1",    {28'd0, x1}, 32'h2);
    chk("t2_c3_ready", {31'd0, in_ready}, 32'd0);
    step();
    chk("t2_c4_ready", {31'd0, in_ready}, 32'd1);
    accept(8'h33, 8'h44);
    chk("t2_b2b_busy", {31'd0, busy}, 32'd1);
    chk("t2_b2b_C",    {24'd0, c_out}, 32'h33);
    chk("t2_b2b_x1",   {28'd0, x1}, 32'h4);
    step();
    step();
    step();
    chk("t2_sent",  {24'd0, sent_count}, 32'd2);
    chk("t2_ready", {31'd0, in_ready}, 32'd1);

    // 3. Timeout in SEND_LO with x2 held low
    x2 = 1'b0;
    accept(8'h5A, 8'h0F);
    for (int i = 0; i < 14; i++) step();
    chk("t3_pre_terr", {31'd0, timeout_err}, 32'd0);
    chk("t3_pre_busy", {31'd0, busy}, 32'd1);
    step();
    chk("t3_terr",  {31'd0, timeout_err}, 32'd1);
    chk("t3_idle",  {31'd0, in_ready}, 32'd1);
    chk("t3_x0",    {31'd0, x0}, 32'd0);
    chk("t3_sent",  {24'd0, sent_count}, 32'd2);
    step();
    chk("t3_pulse", {31'd0, timeout_err}, 32'd0);

    // 4. Ack on the timeout boundary, x2 then held through GAP
    accept(8'h77, 8'h96);
    for (int i = 0; i < 14; i++) step();
    x2 = 1'b1;
    step();
    chk("t4_gap_terr", {31'd0, timeout_err}, 32'd0);
    chk("t4_gap_busy", {31'd0, busy}, 32'd1);
    chk("t4_gap_x0",   {31'd0, x0}, 32'd0);
    step();
    chk("t4_hi_x1", {28'd0, x1}, 32'h9);
    step();
    chk("t4_sent", {24'd0, sent_count}, 32'd3);
    chk("t4_terr", {31'd0, timeout_err}, 32'd0);

    // 5. Reset during SEND_HI
    accept(8'hC3, 8'hE1);
    step();
    x2 = 1'b0;
    step();
    chk("t5_hi_x0", {31'd0, x0}, 32'd1);
    rst = 1'b1;
    step();
    chk("t5_x0",    {31'd0, x0}, 32'd0);
    chk("t5_C",     {24'd0, c_out}, 32'h00);
    chk("t5_sent",  {24'd0, sent_count}, 32'd0);
    chk("t5_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_terr",  {31'd0, timeout_err}, 32'd0);
    rst = 1'b0;
    step();

    // 6. Counter wrap: 5 transactions on the 2-bit instance
    do_reset();
    x2 = 1'b1;
    for (int t = 0; t < 5; t++) begin
      accept(8'(t), 8'(8'h10 + t));
      step();
      step();
      step();
    end
    chk("t6_wrap", {30'd0, w_sent_count}, 32'd1);
    chk("t6_wide", {24'd0, sent_count}, 32'd5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
